// File: rtl/result_deskew_buffer_pkg.sv
// Shared constants and types for the systolic result deskew buffer.
package result_deskew_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_SYSTOLIC_WIDTH = 4;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] lane_word_t;

endpackage

// File: rtl/deskew_delay_line.sv
// Fixed-length valid+data delay line for one systolic lane; STAGES == 0 is a wire.
module deskew_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n ^ clear;
            assign out_valid   = in_valid;
            assign out_data    = in_data;
        end else begin : g_pipe
            logic [STAGES-1:0]                 valid_q;
            logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    data_q  <= '0;
                end else if (clear) begin
                    valid_q <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    data_q[0]  <= in_data;
                    for (int i = 1; i < STAGES; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign out_data  = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/result_deskew_buffer.sv
// Realigns a skewed systolic result stream into whole rows and queues them
// in a small FIFO with sticky overflow / misalignment flags.
module result_deskew_buffer
    import result_deskew_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int SYSTOLIC_WIDTH = DEFAULT_SYSTOLIC_WIDTH,
    parameter int DEPTH          = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic [SYSTOLIC_WIDTH-1:0]          lane_valid,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] lane_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic                               almost_full,
    output logic                               overflow,
    output logic                               misalign
);

    localparam int ROW_W = SYSTOLIC_WIDTH * DATA_WIDTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(DEPTH - SYSTOLIC_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

    logic [SYSTOLIC_WIDTH-1:0] dly_valid;
    logic [ROW_W-1:0]          dly_row;

    // Lane j waits SYSTOLIC_WIDTH-1-j cycles so every lane of a row lands together.
    genvar j;
    generate
        for (j = 0; j < SYSTOLIC_WIDTH; j++) begin : g_lane
            deskew_delay_line #(
                .DATA_WIDTH(DATA_WIDTH),
                .STAGES    (SYSTOLIC_WIDTH - 1 - j)
            ) u_delay (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .in_valid (lane_valid[j]),
                .in_data  (lane_data[(SYSTOLIC_WIDTH-1-j)*DATA_WIDTH +: DATA_WIDTH]),
                .out_valid(dly_valid[j]),
                .out_data (dly_row[(SYSTOLIC_WIDTH-1-j)*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    logic [ROW_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic row_full;
    logic row_mixed;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    // Handshake: a row transfers on every rising edge where out_valid && out_ready;
    // while out_valid && !out_ready the head row and out_valid are held unchanged.
    always_comb begin
        row_full  = &dly_valid;
        row_mixed = (|dly_valid) && !row_full;
        fifo_full = (count == DEPTH_C);
        pop       = out_valid && out_ready;
        push      = row_full && (!fifo_full || pop);
        drop      = row_full && fifo_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            if (drop)      overflow <= 1'b1;
            if (row_mixed) misalign <= 1'b1;
        end
    end

    // Storage carries no reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= dly_row;
    end

    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign almost_full = (count >= AF_C);

endmodule
